vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Pixel-source stage directly downstream of the VGA timing generator.
- Consumes the timing generator's registered vsync and pixel_enable outputs.
- Derives active-area pixel coordinates locally and produces registered 12-bit RGB (4:4:4) for one of four test patterns, including an animated bouncing box.
- Replaces the switch-driven RGB path when driving the VGA DAC.

Parameters:
- X_W, 11, width of the active x coordinate and box x position.
- Y_W, 10, width of the active y coordinate and box y position.
- BAR_SHIFT, 4, log2 of the colour-bar width in pixels.
- CHK_SHIFT, 3, log2 of the checker square size in pixels.
- BOX_SIZE, 32, edge length of the bouncing box in pixels.

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  synchronous reset, active-high.
- vs_i  in  1  vsync from the timing generator; high during the retrace at frame start.
- pixel_enable_i  in  1  active-area strobe from the timing generator.
- mode_i  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box.
- fg_color_i  in  12  foreground colour, {R[11:8],G[7:4],B[3:0]}.
- rgb_o  out  12  registered pixel colour.
- pixel_enable_o  out  1  pixel_enable_i delayed 1 cycle; aligned with rgb_o.
- x_o  out  X_W  current active x counter.
- y_o  out  Y_W  current active y counter.
- frame_cnt_o  out  8  frames started since reset; wraps 255->0.
- frame_start_o  out  1  1-cycle pulse on rising edge of vs_i.

Behaviour:
- Reset (rst_i=1 at posedge) clears all state to 0:
  - rgb_o, pixel_enable_o, x, y, frame_cnt_o, frame_start_o, latched mode, latched colour.
  - width_ff, height_ff, box_x, box_y.
  - Direction bits set to right/down.
  - Reset mid-frame: coordinates restart at 0; output is black until the next pixel_enable_i.
- Edge detect:
  - vs_q and pe_q are registered copies of the inputs.
  - frame_start = vs_i & ~vs_q.
  - line_end = pe_q & ~pixel_enable_i.
- x counter:
  - pixel_enable_i=1: x <= x+1.
  - line_end: x <= 0 and width_ff <= x (measured active width).
- y counter:
  - line_end: y <= y+1.
- Frame start has priority over line_end and pixel counting. On frame_start:
  - x <= 0, y <= 0.
  - height_ff <= y.
  - mode and fg_color latched from mode_i / fg_color_i; changes mid-frame have no visible effect.
  - frame_cnt <= frame_cnt+1.
  - Box update as below.
- Box update, x axis (only if width_ff > BOX_SIZE, otherwise box_x holds):
  - Moving right and box_x+BOX_SIZE >= width_ff: dir <= left, box_x <= box_x-1.
  - Moving right otherwise: box_x+1.
  - Moving left and box_x == 0: dir <= right, box_x <= 1.
  - Moving left otherwise: box_x-1.
- Box update, y axis: identical rules using height_ff, box_y and the down/up direction.
- Pattern, combinational from the current x, y and latched mode/colour, evaluated when pixel_enable_i=1:
  - Mode 0: colour.
  - Mode 1: b = x[BAR_SHIFT+2:BAR_SHIFT]; rgb = {{4{b[2]}},{4{b[1]}},{4{b[0]}}}; bar 0 black, bar 7 white, repeats every 8 bars.
  - Mode 2: x[CHK_SHIFT]^y[CHK_SHIFT] ? colour : 0.
  - Mode 3: colour if box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE, else 0.
- Output timing:
  - rgb_o <= pixel_enable_i ? pattern : 0, with 1-cycle latency.
  - pixel_enable_o <= pixel_enable_i.
  - frame_start_o registered, 1 cycle after the vs_i rising edge.
- Widths and wrap:
  - Box comparisons are done at X_W+1 / Y_W+1 bits; no overflow.
  - x and y wrap silently at 2^X_W / 2^Y_W.

Test Plan:
- Reset: rst_i=1 with vs_i=pixel_enable_i=1 -> all outputs 0 the next cycle; after release, the first vs_i rise gives frame_start_o=1 for exactly 1 cycle and frame_cnt_o=1.
- Solid mode with latched colour: mode_i=0, fg_color_i=12'hF0A, vs pulse, then 16-pixel lines -> rgb_o=12'hF0A exactly 1 cycle after each pixel_enable_i high cycle, 0 elsewhere. Changing fg_color_i to 12'h123 mid-frame has no effect until the next frame.
- Colour bars: mode_i=1, BAR_SHIFT=4, 128-pixel lines -> pixels 0-15 give 12'h000, 16-31 give 12'h00F, 32-47 give 12'h0F0, ..., 112-127 give 12'hFFF.
- Checker: mode_i=2, CHK_SHIFT=3 -> line 0 pixels 0-7 give 0 and 8-15 give colour; line 8 is inverted.
- Box bounce: mode_i=3, BOX_SIZE=4, frames of 8x6 pixels -> box_x steps 1,2,3,4 then 3 (reverse at 4+4>=8) ... 0 then 1; box_y reverses at 2; box pixels appear at the expected coordinates.
- Priority: vs_i rise in the same cycle as line_end -> y_o=0 and x_o=0 the next cycle, height_ff captured, no y increment.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Test-pattern pixel source fed by the VGA timing generator. Rebuilds the
// active-area x/y coordinates from vsync and the active strobe, and produces
// a registered 12-bit RGB (4:4:4) pixel for one of four patterns: solid
// colour, colour bars, checkerboard or an animated bouncing box.
//
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous reset, active-high
//   vs_i           vsync, high during retrace at frame start
//   pixel_enable_i active-area strobe
//   mode_i         pattern select: 0 solid, 1 bars, 2 checker, 3 box
//   fg_color_i     foreground colour {R,G,B}
//   rgb_o          registered pixel colour (black outside active area)
//   pixel_enable_o pixel_enable_i delayed one cycle, aligned with rgb_o
//   x_o, y_o       current active x / y counters
//   frame_cnt_o    frames started since reset (wraps)
//   frame_start_o  one-cycle pulse after the vs_i rising edge
module vga_pattern_gen #(
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int BAR_SHIFT = 4,
  parameter int CHK_SHIFT = 3,
  parameter int BOX_SIZE  = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           vs_i,
  input  logic           pixel_enable_i,
  input  logic [1:0]     mode_i,
  input  logic [11:0]    fg_color_i,
  output logic [11:0]    rgb_o,
  output logic           pixel_enable_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [7:0]     frame_cnt_o,
  output logic           frame_start_o
);

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHK   = 2'd2;
  localparam logic [1:0] MODE_BOX   = 2'd3;

  localparam logic [X_W:0]   BOX_XW = (X_W+1)'(BOX_SIZE);
  localparam logic [Y_W:0]   BOX_YW = (Y_W+1)'(BOX_SIZE);
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  logic           vs_q, pe_q;
  logic [X_W-1:0] x, width_ff, box_x, box_x_nxt;
  logic [Y_W-1:0] y, height_ff, box_y, box_y_nxt;
  logic           dir_left, dir_left_nxt, dir_up, dir_up_nxt;
  logic [1:0]     mode_q;
  logic [11:0]    color_q, pattern;
  logic           frame_start, line_end, in_box;
  logic [2:0]     bar;
  logic [X_W:0]   box_x_end;
  logic [Y_W:0]   box_y_end;

  always_comb begin
    frame_start = vs_i & ~vs_q;
    line_end    = pe_q & ~pixel_enable_i;
    bar         = x[BAR_SHIFT+2:BAR_SHIFT];
    // One extra bit so box_pos + BOX_SIZE never wraps.
    box_x_end   = {1'b0, box_x} + BOX_XW;
    box_y_end   = {1'b0, box_y} + BOX_YW;
    in_box      = (x >= box_x) && ({1'b0, x} < box_x_end) &&
                  (y >= box_y) && ({1'b0, y} < box_y_end);

    pattern = 12'h000;
    case (mode_q)
      MODE_SOLID: pattern = color_q;
      MODE_BARS:  pattern = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      MODE_CHK:   pattern = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? color_q : 12'h000;
      MODE_BOX:   pattern = in_box ? color_q : 12'h000;
      default:    pattern = 12'h000;
    endcase
  end

  // Bounce step, applied once per frame. The box only moves on an axis whose
  // measured extent can actually hold it.
  always_comb begin
    box_x_nxt    = box_x;
    dir_left_nxt = dir_left;
    if ({1'b0, width_ff} > BOX_XW) begin
      if (!dir_left) begin
        if (box_x_end >= {1'b0, width_ff}) begin
          dir_left_nxt = 1'b1;
          box_x_nxt    = box_x - X_ONE;
        end else begin
          box_x_nxt    = box_x + X_ONE;
        end
      end else if (box_x == '0) begin
        dir_left_nxt = 1'b0;
        box_x_nxt    = X_ONE;
      end else begin
        box_x_nxt    = box_x - X_ONE;
      end
    end

    box_y_nxt  = box_y;
    dir_up_nxt = dir_up;
    if ({1'b0, height_ff} > BOX_YW) begin
      if (!dir_up) begin
        if (box_y_end >= {1'b0, height_ff}) begin
          dir_up_nxt = 1'b1;
          box_y_nxt  = box_y - Y_ONE;
        end else begin
          box_y_nxt  = box_y + Y_ONE;
        end
      end else if (box_y == '0) begin
        dir_up_nxt = 1'b0;
        box_y_nxt  = Y_ONE;
      end else begin
        box_y_nxt  = box_y - Y_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q           <= 1'b0;
      pe_q           <= 1'b0;
      x              <= '0;
      y              <= '0;
      width_ff       <= '0;
      height_ff      <= '0;
      box_x          <= '0;
      box_y          <= '0;
      dir_left       <= 1'b0;
      dir_up         <= 1'b0;
      mode_q         <= 2'd0;
      color_q        <= 12'h000;
      frame_cnt_o    <= 8'd0;
      frame_start_o  <= 1'b0;
      pixel_enable_o <= 1'b0;
      rgb_o          <= 12'h000;
    end else begin
      vs_q           <= vs_i;
      pe_q           <= pixel_enable_i;
      frame_start_o  <= frame_start;
      pixel_enable_o <= pixel_enable_i;
      rgb_o          <= pixel_enable_i ? pattern : 12'h000;

      // Frame start overrides any coincident line end or pixel count.
      if (frame_start) begin
        x           <= '0;
        y           <= '0;
        height_ff   <= y;
        mode_q      <= mode_i;
        color_q     <= fg_color_i;
        frame_cnt_o <= frame_cnt_o + 8'd1;
        box_x       <= box_x_nxt;
        box_y       <= box_y_nxt;
        dir_left    <= dir_left_nxt;
        dir_up      <= dir_up_nxt;
      end else if (pixel_enable_i) begin
        x <= x + X_ONE;
      end else if (line_end) begin
        x        <= '0;
        width_ff <= x;
        y        <= y + Y_ONE;
      end
    end
  end

  assign x_o = x;
  assign y_o = y;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: a cycle-by-cycle vector table for reset,
// solid colour, mid-frame colour change and frame-start priority, followed by
// hand-written sequences for bars, checkerboard and the bouncing box.
module tb_vga_pattern_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        vs_i;
  logic        pixel_enable_i;
  logic [1:0]  mode_i;
  logic [11:0] fg_color_i;
  logic [11:0] rgb_o;
  logic        pixel_enable_o;
  logic [10:0] x_o;
  logic [9:0]  y_o;
  logic [7:0]  frame_cnt_o;
  logic        frame_start_o;

  int n_cmp = 0;
  int n_bad = 0;

  vga_pattern_gen #(
    .X_W(11), .Y_W(10), .BAR_SHIFT(4), .CHK_SHIFT(3), .BOX_SIZE(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .vs_i           (vs_i),
    .pixel_enable_i (pixel_enable_i),
    .mode_i         (mode_i),
    .fg_color_i     (fg_color_i),
    .rgb_o          (rgb_o),
    .pixel_enable_o (pixel_enable_o),
    .x_o            (x_o),
    .y_o            (y_o),
    .frame_cnt_o    (frame_cnt_o),
    .frame_start_o  (frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vs;
    logic        pe;
    logic [1:0]  mode;
    logic [11:0] col;
    logic [11:0] e_rgb;
    logic        e_pe;
    logic        e_fs;
    logic [7:0]  e_fc;
    logic [10:0] e_x;
    logic [9:0]  e_y;
  } vec_t;

  vec_t vec[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic vs, input logic pe);
    vs_i = vs;
    pixel_enable_i = pe;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [11:0] bar_color(input int px);
    logic [11:0] tbl[8];
    tbl = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
    return tbl[(px / 16) % 8];
  endfunction

  initial begin
    int bx[10];
    int by[10];
    logic [11:0] e;

    // vs, pe, mode, col | rgb, pe_o, fs, fc, x, y
    vec[0]  = '{1'b1, 1'b0, 2'd0, 12'hF0A, 12'h000, 1'b0, 1'b1, 8'd1, 11'd0, 10'd0};
    vec[1]  = '{1'b0, 1'b0, 2'd0, 12'hF0A, 12'h000, 1'b0, 1'b0, 8'd1, 11'd0, 10'd0};
    vec[2]  = '{1'b0, 1'b1, 2'd0, 12'hF0A, 12'hF0A, 1'b1, 1'b0, 8'd1, 11'd1, 10'd0};
    vec[3]  = '{1'b0, 1'b1, 2'd0, 12'h123, 12'hF0A, 1'b1, 1'b0, 8'd1, 11'd2, 10'd0};
    vec[4]  = '{1'b0, 1'b0, 2'd0, 12'h123, 12'h000, 1'b0, 1'b0, 8'd1, 11'd0, 10'd1};
    vec[5]  = '{1'b0, 1'b1, 2'd1, 12'h123, 12'hF0A, 1'b1, 1'b0, 8'd1, 11'd1, 10'd1};
    vec[6]  = '{1'b0, 1'b0, 2'd0, 12'h123, 12'h000, 1'b0, 1'b0, 8'd1, 11'd0, 10'd2};
    vec[7]  = '{1'b1, 1'b0, 2'd0, 12'h123, 12'h000, 1'b0, 1'b1, 8'd2, 11'd0, 10'd0};
    vec[8]  = '{1'b0, 1'b1, 2'd0, 12'h456, 12'h123, 1'b1, 1'b0, 8'd2, 11'd1, 10'd0};
    // vs rise coincides with line end: frame start wins, no y increment
    vec[9]  = '{1'b1, 1'b0, 2'd0, 12'h123, 12'h000, 1'b0, 1'b1, 8'd3, 11'd0, 10'd0};
    vec[10] = '{1'b1, 1'b1, 2'd0, 12'h789, 12'h123, 1'b1, 1'b0, 8'd3, 11'd1, 10'd0};
    vec[11] = '{1'b0, 1'b0, 2'd0, 12'h789, 12'h000, 1'b0, 1'b0, 8'd3, 11'd0, 10'd1};

    bx = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    by = '{0, 0, 1, 2, 1, 0, 1, 2, 1, 0};

    // Reset with vs and pixel_enable both high
    rst_i = 1'b1; vs_i = 1'b1; pixel_enable_i = 1'b1; mode_i = 2'd0; fg_color_i = 12'hFFF;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("rst_rgb", 32'(rgb_o), 32'h0);
    check("rst_pe", 32'(pixel_enable_o), 32'h0);
    check("rst_x", 32'(x_o), 32'h0);
    check("rst_y", 32'(y_o), 32'h0);
    check("rst_fc", 32'(frame_cnt_o), 32'h0);
    check("rst_fs", 32'(frame_start_o), 32'h0);
    vs_i = 1'b0; pixel_enable_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cyc(1'b0, 1'b0);
    check("rel_fs", 32'(frame_start_o), 32'h0);

    for (int i = 0; i < 12; i++) begin
      mode_i = vec[i].mode;
      fg_color_i = vec[i].col;
      cyc(vec[i].vs, vec[i].pe);
      check($sformatf("v%0d_rgb", i), 32'(rgb_o), 32'(vec[i].e_rgb));
      check($sformatf("v%0d_pe", i), 32'(pixel_enable_o), 32'(vec[i].e_pe));
      check($sformatf("v%0d_fs", i), 32'(frame_start_o), 32'(vec[i].e_fs));
      check($sformatf("v%0d_fc", i), 32'(frame_cnt_o), 32'(vec[i].e_fc));
      check($sformatf("v%0d_x", i), 32'(x_o), 32'(vec[i].e_x));
      check($sformatf("v%0d_y", i), 32'(y_o), 32'(vec[i].e_y));
    end

    // Solid colour, 16-pixel lines
    mode_i = 2'd0; fg_color_i = 12'hF0A;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    fg_color_i = 12'h123;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 16; p++) begin
        cyc(1'b0, 1'b1);
        check($sformatf("solid_l%0d_p%0d", l, p), 32'(rgb_o), 32'hF0A);
      end
      cyc(1'b0, 1'b0);
      check($sformatf("solid_blank_l%0d", l), 32'(rgb_o), 32'h0);
    end

    // Colour bars, one 128-pixel line
    mode_i = 2'd1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int p = 0; p < 128; p++) begin
      cyc(1'b0, 1'b1);
      check($sformatf("bar_p%0d", p), 32'(rgb_o), 32'(bar_color(p)));
    end
    cyc(1'b0, 1'b0);

    // Checkerboard, 9 lines of 16 pixels
    mode_i = 2'd2; fg_color_i = 12'hABC;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int l = 0; l < 9; l++) begin
      for (int p = 0; p < 16; p++) begin
        cyc(1'b0, 1'b1);
        e = (((p / 8) + (l / 8)) % 2 == 1) ? 12'hABC : 12'h000;
        check($sformatf("chk_l%0d_p%0d", l, p), 32'(rgb_o), 32'(e));
      end
      cyc(1'b0, 1'b0);
    end

    // Reset mid-line with pixel_enable high: coordinates and output cleared
    cyc(1'b0, 1'b1);
    rst_i = 1'b1;
    cyc(1'b0, 1'b1);
    check("mid_rst_rgb", 32'(rgb_o), 32'h0);
    check("mid_rst_x", 32'(x_o), 32'h0);
    check("mid_rst_fc", 32'(frame_cnt_o), 32'h0);
    rst_i = 1'b0;
    cyc(1'b0, 1'b0);
    check("post_rst_rgb", 32'(rgb_o), 32'h0);

    // Bouncing box, 10 frames of 8x6 pixels
    mode_i = 2'd3; fg_color_i = 12'hFFF;
    for (int f = 0; f < 10; f++) begin
      cyc(1'b1, 1'b0);
      check($sformatf("box_f%0d_fc", f), 32'(frame_cnt_o), 32'(f + 1));
      cyc(1'b0, 1'b0);
      for (int l = 0; l < 6; l++) begin
        for (int p = 0; p < 8; p++) begin
          cyc(1'b0, 1'b1);
          e = (p >= bx[f] && p < bx[f] + 4 && l >= by[f] && l < by[f] + 4) ? 12'hFFF : 12'h000;
          check($sformatf("box_f%0d_l%0d_p%0d", f, l, p), 32'(rgb_o), 32'(e));
        end
        cyc(1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
